// File: rtl/mem_arb.sv
// -----------------------------------------------------------------------------
// mem_arb: two-master arbiter in front of a single-ported synchronous memory.
//
// Master 0 is the core and master 1 is the loader. Each cycle at most one of
// them is granted. When both request, the current owner keeps the memory for
// up to MAX_BURST consecutive grants. After that the other master wins the
// tie, so neither side can starve the other. A granted read returns its data
// one cycle later through the granted master's rvalid/rdata.
//
// Handshake: mX_req is a request held by the master. mX_gnt is combinational
// from the requests and the arbitration state. The access (address, write data,
// byte enables, write strobe) completes in the cycle in which mX_gnt is high.
// A master whose req is high and gnt is low must hold its request and try
// again. mX_rvalid pulses for one cycle, one cycle after a granted read, and
// cannot be back-pressured.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   mX_req/we/addr/wdata/be   master X request and access fields (X = 0, 1)
//   mX_gnt                    master X access accepted this cycle
//   mX_rvalid/mX_rdata        master X read response
//   mem_addr/wdata/we/be      muxed memory request (all zero when idle)
//   mem_rdata                 memory read data, valid one cycle after address
// -----------------------------------------------------------------------------
module mem_arb #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 4     // legal range 1..15
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [3:0]        m0_be,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [3:0]        m1_be,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    // Arbitration state: last granted master, its run of consecutive grants,
    // and the one-hot target of the read whose data arrives this cycle.
    logic       owner_q, owner_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [1:0] rd_pend_q, rd_pend_d;

    logic gnt0, gnt1;

    // -------------------------------------------------------------------------
    // Grant decision. This path is combinational so that an access can finish
    // in its request cycle. Reset masks every grant, whatever the requests are.
    // -------------------------------------------------------------------------
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            case ({m1_req, m0_req})
                2'b01: gnt0 = 1'b1;
                2'b10: gnt1 = 1'b1;
                2'b11: begin
                    // While under quota, the owner keeps winning ties.
                    // Once the quota is used up, the other master wins.
                    if (cnt_q < BURST_LIM) begin
                        gnt0 = ~owner_q;
                        gnt1 =  owner_q;
                    end else begin
                        gnt0 =  owner_q;
                        gnt1 = ~owner_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;

    // -------------------------------------------------------------------------
    // Next-state logic for the arbitration state.
    // -------------------------------------------------------------------------
    always_comb begin
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        rd_pend_d = 2'b00;

        if (!(gnt0 || gnt1)) begin
            // An idle cycle breaks the run. Ownership is kept, so the
            // previous owner starts the next tie with a fresh quota.
            cnt_d = 4'd0;
        end else if (gnt1 == owner_q) begin
            cnt_d = (cnt_q >= BURST_LIM) ? BURST_LIM : cnt_q + 4'd1;
        end else begin
            owner_d = gnt1;
            cnt_d   = 4'd1;
        end

        // Only reads expect a response. Writes leave rd_pend clear.
        rd_pend_d = {gnt1 & ~m1_we, gnt0 & ~m0_we};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q   <= 1'b0;
            cnt_q     <= 4'd0;
            rd_pend_q <= 2'b00;
        end else begin
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    // -------------------------------------------------------------------------
    // Memory request mux. Drives all zeros when nobody is granted.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        if (gnt0) begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_we    = m0_we;
            mem_be    = m0_be;
        end else if (gnt1) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_we    = m1_we;
            mem_be    = m1_be;
        end
    end

    // -------------------------------------------------------------------------
    // Read return. rd_pend is already cleared by the async reset. The extra
    // rst term keeps rvalid low during the first reset, before the register
    // has been cleared at least once.
    // -------------------------------------------------------------------------
    assign m0_rvalid = rd_pend_q[0] & ~rst;
    assign m1_rvalid = rd_pend_q[1] & ~rst;
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_mem_arb: self-checking bench for mem_arb (MAX_BURST = 4).
//
// Directed steps cover reset, the tie-break rotation, a single write, a single
// read, quota refresh after an idle cycle, and an async reset mid-read.
// Randomized traffic follows, checked every cycle against a reference model.
// The model keeps the winner of the last grant, the length of its current
// streak, and which master is owed read data.
// -----------------------------------------------------------------------------
module tb_mem_arb;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic [3:0]    m0_be, m1_be;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_we;
    logic [3:0]    mem_be;

    mem_arb #(.DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_be(m0_be), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_be(m1_be), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- counters ----------------
    int n_pass   = 0;
    int n_checks = 0;

    // ---------------- reference model state ----------------
    int m_last   = 0;    // master that received the latest grant
    int m_streak = 0;    // consecutive grants to m_last (capped at MB)
    int m_pend   = -1;   // master owed read data this cycle, -1 if none

    int exp_seq[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    int exp_026[5] = '{0, 0, 0, 0, 1};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic set_m(input int who, input logic req, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [3:0] be);
        if (who == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wd; m0_be = be;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wd; m1_be = be;
        end
    endtask

    // Winner per the arbitration policy: a single requester always wins.
    // On a tie the last winner keeps the memory until its streak reaches the
    // quota, and then the other master takes it.
    function automatic int pick();
        if (rst) return -1;
        if (m0_req && !m1_req) return 0;
        if (m1_req && !m0_req) return 1;
        if (m0_req && m1_req) return (m_streak < MB) ? m_last : 1 - m_last;
        return -1;
    endfunction

    // One clock cycle. Called just after a negedge with the inputs in place.
    // Drives mem_rdata, checks every output against the model, then advances
    // the model across the posedge.
    task automatic step(input logic [DW-1:0] rd);
        int            w;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic [3:0]    e_be;
        mem_rdata = rd;
        #1;
        if (rst) begin
            m_last = 0; m_streak = 0; m_pend = -1;
        end
        w = pick();
        e_we = 1'b0; e_addr = '0; e_wd = '0; e_be = 4'h0;
        if (w == 0) begin
            e_we = m0_we; e_addr = m0_addr; e_wd = m0_wdata; e_be = m0_be;
        end else if (w == 1) begin
            e_we = m1_we; e_addr = m1_addr; e_wd = m1_wdata; e_be = m1_be;
        end
        check("m0_gnt",    m0_gnt,    w == 0);
        check("m1_gnt",    m1_gnt,    w == 1);
        check("mem_we",    mem_we,    e_we);
        check("mem_addr",  mem_addr,  e_addr);
        check("mem_wdata", mem_wdata, e_wd);
        check("mem_be",    mem_be,    e_be);
        check("m0_rvalid", m0_rvalid, m_pend == 0);
        check("m1_rvalid", m1_rvalid, m_pend == 1);
        check("m0_rdata",  m0_rdata,  (m_pend == 0) ? rd : '0);
        check("m1_rdata",  m1_rdata,  (m_pend == 1) ? rd : '0);
        @(posedge clk);
        if (rst) begin
            m_last = 0; m_streak = 0; m_pend = -1;
        end else begin
            if (w < 0) m_streak = 0;
            else if (w == m_last) m_streak = (m_streak >= MB) ? MB : m_streak + 1;
            else begin
                m_last = w; m_streak = 1;
            end
            m_pend = (w >= 0 && !e_we) ? w : -1;
        end
        @(negedge clk);
    endtask

    task automatic rand_inputs(input bit bursty);
        for (int k = 0; k < 2; k++)
            set_m(k, bursty ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), $urandom(), $urandom(),
                  4'($urandom_range(0, 15)));
    endtask

    initial begin
        // Reset with both masters requesting: nothing may leak out.
        rst = 1'b1;
        mem_rdata = '0;
        set_m(0, 1'b1, 1'b0, 32'h4, 32'h1, 4'hF);
        set_m(1, 1'b1, 1'b1, 32'h8, 32'h2, 4'hF);
        step($urandom());
        step($urandom());
        #1;
        check("rst_gnt0", m0_gnt, 0);
        check("rst_gnt1", m1_gnt, 0);
        check("rst_mem_we", mem_we, 0);
        rst = 1'b0;

        // Continuous tie of reads: four to m0, four to m1, back to m0.
        for (int i = 0; i < 9; i++) begin
            set_m(0, 1'b1, 1'b0, 32'(i * 4), '0, 4'hF);
            set_m(1, 1'b1, 1'b0, 32'(32'h100 + i * 4), '0, 4'hF);
            #1;
            check("seq_m1_gnt", m1_gnt, exp_seq[i] == 1);
            check("seq_m0_gnt", m0_gnt, exp_seq[i] == 0);
            if (i > 0) check("seq_rvalid", (exp_seq[i-1] == 1) ? m1_rvalid : m0_rvalid, 1);
            step($urandom());
        end

        // Single write from the loader.
        set_m(0, 1'b0, 1'b0, '0, '0, 4'h0);
        set_m(1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        #1;
        check("wr_gnt1", m1_gnt, 1);
        check("wr_mem_we", mem_we, 1);
        check("wr_mem_addr", mem_addr, 32'h10);
        check("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        step($urandom());
        set_m(1, 1'b0, 1'b0, '0, '0, 4'h0);
        #1;
        check("wr_no_rvalid", m1_rvalid, 0);
        step($urandom());

        // Single read from the core, with data returned one cycle later.
        set_m(0, 1'b1, 1'b0, 32'h40, '0, 4'hF);
        #1;
        check("rd_gnt0", m0_gnt, 1);
        check("rd_mem_addr", mem_addr, 32'h40);
        step($urandom());
        set_m(0, 1'b0, 1'b0, '0, '0, 4'h0);
        mem_rdata = 32'h12345678;
        #1;
        check("rd_m0_rvalid", m0_rvalid, 1);
        check("rd_m0_rdata", m0_rdata, 32'h12345678);
        check("rd_m1_rvalid", m1_rvalid, 0);
        step(32'h12345678);

        // An idle cycle refreshes the owner's quota but keeps its ownership.
        for (int i = 0; i < 2; i++) begin
            set_m(0, 1'b1, 1'b0, 32'h200, '0, 4'hF);
            step($urandom());
        end
        set_m(0, 1'b0, 1'b0, '0, '0, 4'h0);
        step($urandom());
        for (int i = 0; i < 5; i++) begin
            set_m(0, 1'b1, 1'b0, 32'h300, '0, 4'hF);
            set_m(1, 1'b1, 1'b0, 32'h400, '0, 4'hF);
            #1;
            check("idle_gnt1", m1_gnt, exp_026[i] == 1);
            step($urandom());
        end

        // Async reset in the middle of a read response.
        set_m(0, 1'b0, 1'b0, '0, '0, 4'h0);
        set_m(1, 1'b1, 1'b0, 32'h80, '0, 4'hF);
        step($urandom());
        set_m(0, 1'b1, 1'b0, 32'h84, '0, 4'hF);
        set_m(1, 1'b1, 1'b0, 32'h88, '0, 4'hF);
        #1;
        check("arst_pre_rvalid", m1_rvalid, 1);
        rst = 1'b1;
        #1;
        check("arst_gnt0", m0_gnt, 0);
        check("arst_gnt1", m1_gnt, 0);
        check("arst_rvalid", m1_rvalid, 0);
        check("arst_rdata", m1_rdata, 0);
        check("arst_mem_addr", mem_addr, 0);
        step($urandom());
        step($urandom());
        rst = 1'b0;
        #1;
        check("arst_first_tie", m0_gnt, 1);
        check("arst_no_rvalid", m1_rvalid, 0);
        step($urandom());

        // Randomized traffic, alternating heavy-contention and sparse phases.
        for (int i = 0; i < 400; i++) begin
            rand_inputs(((i / 50) % 2) == 0);
            step($urandom());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
